ccta_pipe: RTL
==============

Name: ccta_pipe

Overview:
- Parametrised, pipelined successor to the CCTA conditional-add block.
- Selects an operand combination from A/B/C per transaction, or accumulates A into an internal saturating accumulator.
- Elastic two-stage datapath with valid/ready on both sides; sits between operand producers and the result consumer in the DSL datapath.
- With default parameters, operand and result widths match the original CCTA (4-bit in, 5-bit out).

Parameters:
- WIDTH, 4, operand width of A, B, C.
- GUARD, 1, extra result bits; result/accumulator width RW = WIDTH+GUARD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction offered.
- in_ready  output  1  block accepts transaction this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- C  input  WIDTH  operand C, unsigned.
- ctrl  input  2  mode, sampled with the transaction.
- clr_acc  input  1  clear accumulator and ovf (single-cycle pulse, independent of handshake).
- out_valid  output  1  result q valid.
- out_ready  input  1  consumer accepts q.
- q  output  RW  result, unsigned.
- ovf  output  1  sticky saturation flag.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, q=0, acc=0, ovf=0. in_ready is 1 once rst deasserts.
- Handshake:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - adv2 = !s2_valid || out_ready.
  - adv1 = adv2 (s1 moves to s2 when s1_valid).
  - in_ready = !s1_valid || adv2 (combinational, no dependency on in_valid).
  - Full throughput: one result per cycle when out_ready=1.
- Stage 1 registers A, B, C, ctrl on input transfer.
- Stage 2 computes and registers q on s1->s2 move. out_valid=s2_valid.
- Latency: 2 cycles from input transfer to out_valid, with no backpressure.
- Modes (all arithmetic unsigned, computed at full width, then saturated to 2^RW-1):
  - ctrl=0: q = A+B.
  - ctrl=1: q = A+C.
  - ctrl=2: acc_next = sat(acc + A); acc <= acc_next; q = acc_next.
  - ctrl=3: q = sat(A+B+C).
- ovf is set when any mode saturates; it is sticky until clr_acc or rst. With GUARD=1, modes 0/1 never saturate.
- acc updates only when a ctrl=2 transaction moves s1->s2. A held (stalled) transaction does not update acc twice.
- clr_acc in the same cycle as a ctrl=2 s1->s2 move: clear applies first, so acc <= sat(0+A), q = A, and ovf <= (saturation of that op).
- clr_acc with no move: acc <= 0, ovf <= 0. Queued results in s2 are unaffected.
- Backpressure:
  - With out_ready=0, q/out_valid hold stable and s1 holds.
  - A third transaction is refused (in_ready=0) while both stages are full.
- rst mid-operation: all in-flight transactions are discarded, acc and ovf are cleared, and no out_valid pulse appears after release until a new input transfer.
- Inputs sampled only on transfer; A/B/C/ctrl changes without in_valid are ignored.

Decomposition:
- Package ccta_pkg:
  - mode constants MODE_AB=0, MODE_AC=1, MODE_ACC=2, MODE_ABC=3;
  - function sat_add(width-generic saturating unsigned add).
- One natural sub-module: ccta_stage, the elastic pipeline register (valid/ready slice). It is instantiated twice; the arithmetic sits between the instances.

Test Plan:
- Reset, then ctrl=0, A=9, B=7, one transfer -> out_valid two cycles later with q=16, ovf=0. Then ctrl=1, A=15, C=15 -> q=30.
- ctrl=2, A=15 on three consecutive transfers -> q=15, 30, 31; ovf=1 from the third result. Then pulse clr_acc; next ctrl=2, A=3 -> q=3, ovf=0.
- ctrl=3, A=B=C=15 -> q=31, ovf=1. Then ctrl=0, A=1, B=2 -> q=3 with ovf still 1.
- out_ready=0 while streaming 4 transfers -> exactly 2 accepted, in_ready=0, q holds first result. Release out_ready -> results appear in order, no loss or duplication; acc advanced once per ctrl=2 op.
- clr_acc coincident with a ctrl=2 A=5 s1->s2 move, with acc=20 -> q=5, acc=5.
- Assert rst with two transactions in flight -> out_valid=0 immediately, q=0, acc=0. After release, no spurious result; a new transfer ctrl=0, A=2, B=2 -> q=4 after 2 cycles.

Source files
------------

// File: rtl/ccta_pkg.sv
// Shared mode encodings and the saturating adder used by the CCTA pipeline.
package ccta_pkg;

   localparam logic [1:0] MODE_AB  = 2'd0;
   localparam logic [1:0] MODE_AC  = 2'd1;
   localparam logic [1:0] MODE_ACC = 2'd2;
   localparam logic [1:0] MODE_ABC = 2'd3;

   // Internal arithmetic width; the result width passed to sat_add must be below this.
   localparam int unsigned SAT_W = 32;
   localparam int unsigned SAT_W1 = SAT_W + 1;

   // Unsigned a+b saturated to 2^rw-1. Returns {saturated_flag, value}.
   function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                              input logic [SAT_W-1:0] b,
                                              input int unsigned rw);
      logic [SAT_W:0] sum;
      logic [SAT_W:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (SAT_W1'(1) << rw) - SAT_W1'(1);
      if (sum > lim) begin
         return {1'b1, lim[SAT_W-1:0]};
      end
      return {1'b0, sum[SAT_W-1:0]};
   endfunction

endpackage

// File: rtl/ccta_pipe_if.sv
// Operand/result handshake bundle between producers, the CCTA pipe and the consumer.
interface ccta_pipe_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned GUARD = 1
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         A;
   logic [WIDTH-1:0]         B;
   logic [WIDTH-1:0]         C;
   logic [1:0]               ctrl;
   logic                     clr_acc;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH+GUARD-1:0]   q;
   logic                     ovf;

   modport master (
      output in_valid, A, B, C, ctrl, clr_acc, out_ready,
      input  in_ready, out_valid, q, ovf
   );

   modport slave (
      input  in_valid, A, B, C, ctrl, clr_acc, out_ready,
      output in_ready, out_valid, q, ovf
   );
endinterface

// File: rtl/ccta_stage.sv
// Elastic pipeline register: loads when empty or when downstream drains it.
module ccta_stage #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] data_o
);
   logic          valid_q;
   logic [DW-1:0] data_q;

   // Slot can advance whenever it is empty or its content is being taken this cycle.
   always_comb ready_o = !valid_q || ready_i;

   // Data only loads on an accepted beat so an unloaded slot keeps its last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (ready_o) begin
         valid_q <= valid_i;
         if (valid_i) begin
            data_q <= data_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/ccta_pipe.sv
// Two-stage elastic conditional adder / saturating accumulator.
module ccta_pipe
   import ccta_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned GUARD = 1
) (
   input logic        clk,
   input logic        rst,
   ccta_pipe_if.slave bus
);
   localparam int unsigned RW  = WIDTH + GUARD;
   localparam int unsigned S1W = 3 * WIDTH + 2;

   logic             s1_valid;
   logic [S1W-1:0]   s1_data;
   logic             adv2;
   logic [WIDTH-1:0] a1, b1, c1;
   logic [1:0]       m1;
   logic [SAT_W:0]   r;
   logic [RW-1:0]    res;
   logic             sat;
   logic             move;
   logic [RW-1:0]    acc_q, acc_d, acc_base;
   logic             ovf_q, ovf_d, ovf_base;
   logic             unused_hi;

   ccta_stage #(.DW(S1W)) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .valid_i (bus.in_valid),
      .ready_o (bus.in_ready),
      .data_i  ({bus.ctrl, bus.C, bus.B, bus.A}),
      .valid_o (s1_valid),
      .ready_i (adv2),
      .data_o  (s1_data)
   );

   assign a1   = s1_data[WIDTH-1:0];
   assign b1   = s1_data[2*WIDTH-1:WIDTH];
   assign c1   = s1_data[3*WIDTH-1:2*WIDTH];
   assign m1   = s1_data[3*WIDTH+1:3*WIDTH];
   assign move = s1_valid && adv2;

   // Result datapath; a clear in the same cycle is seen by the accumulate before it adds.
   always_comb begin
      acc_base = bus.clr_acc ? '0 : acc_q;
      ovf_base = bus.clr_acc ? 1'b0 : ovf_q;
      case (m1)
         MODE_AB:  r = sat_add(SAT_W'(a1), SAT_W'(b1), RW);
         MODE_AC:  r = sat_add(SAT_W'(a1), SAT_W'(c1), RW);
         MODE_ACC: r = sat_add(SAT_W'(acc_base), SAT_W'(a1), RW);
         default:  r = sat_add(SAT_W'(a1) + SAT_W'(b1), SAT_W'(c1), RW);
      endcase
      res = r[RW-1:0];
      sat = r[SAT_W];
   end

   assign unused_hi = ^r[SAT_W-1:RW];

   // Accumulator and sticky flag only change when a transaction actually moves into stage 2.
   always_comb begin
      acc_d = acc_base;
      ovf_d = ovf_base;
      if (move) begin
         ovf_d = ovf_base | sat;
         if (m1 == MODE_ACC) begin
            acc_d = res;
         end
      end
   end

   // Accumulator state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   ccta_stage #(.DW(RW)) u_s2 (
      .clk     (clk),
      .rst     (rst),
      .valid_i (s1_valid),
      .ready_o (adv2),
      .data_i  (res),
      .valid_o (bus.out_valid),
      .ready_i (bus.out_ready),
      .data_o  (bus.q)
   );

   assign bus.ovf = ovf_q;
endmodule
